// File: rtl/scrypt_pkg.sv
// rtl/scrypt_pkg.sv - shared widths, timeout default and BlockMix state encoding
package scrypt_pkg;

  localparam int BLOCK_W           = 1024;
  localparam int HALF_W            = 512;
  localparam int SALSA_TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MIX0 = 3'd1,
    S_GAP0 = 3'd2,
    S_MIX1 = 3'd3,
    S_GAP1 = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } bm_state_t;

endpackage

// File: rtl/block_mix_fsm.sv
// rtl/block_mix_fsm.sv - BlockMix sequencer: two Salsa20/8 invocations split by a one-cycle gap
// Optional wait timeout compiled in with BLOCK_MIX_TIMEOUT_EN.
module block_mix_fsm
  import scrypt_pkg::*;
#(
  parameter int SALSA_TIMEOUT = SALSA_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic init,
  input  logic salsa_valid,
  output logic load_b,
  output logic mix0,
  output logic mix1,
  output logic cap_y0,
  output logic cap_y1,
  output logic salsa_init,
  output logic valid,
  output logic err
);

  bm_state_t state;

`ifdef BLOCK_MIX_TIMEOUT_EN
  localparam logic [3:0] WAIT_LAST = 4'(SALSA_TIMEOUT - 1);
  logic [3:0] wait_cnt;
  logic       timed_out;
  assign timed_out = (wait_cnt == WAIT_LAST);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
`ifdef BLOCK_MIX_TIMEOUT_EN
      wait_cnt <= 4'd0;
`endif
    end else begin
`ifdef BLOCK_MIX_TIMEOUT_EN
      wait_cnt <= 4'd0;
`endif
      case (state)
        S_IDLE: if (init) state <= S_MIX0;
        S_MIX0: begin
          if (salsa_valid) state <= S_GAP0;
`ifdef BLOCK_MIX_TIMEOUT_EN
          else if (timed_out) state <= S_ERR;
          wait_cnt <= wait_cnt + 4'd1;
`endif
        end
        // The core still shows DONE here; one low cycle of init lets it return to IDLE.
        S_GAP0: state <= S_MIX1;
        S_MIX1: begin
          if (salsa_valid) state <= S_GAP1;
`ifdef BLOCK_MIX_TIMEOUT_EN
          else if (timed_out) state <= S_ERR;
          wait_cnt <= wait_cnt + 4'd1;
`endif
        end
        S_GAP1: state <= S_DONE;
        S_DONE: if (!init) state <= S_IDLE;
`ifdef BLOCK_MIX_TIMEOUT_EN
        S_ERR:  if (!init) state <= S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign load_b     = (state == S_IDLE) && init;
  assign mix0       = (state == S_MIX0);
  assign mix1       = (state == S_MIX1);
  assign cap_y0     = mix0 && salsa_valid;
  assign cap_y1     = mix1 && salsa_valid;
  assign salsa_init = mix0 || mix1;
  assign valid      = (state == S_DONE);

`ifdef BLOCK_MIX_TIMEOUT_EN
  assign err = (state == S_ERR);
`else
  logic unused_timeout;
  assign unused_timeout = (SALSA_TIMEOUT != 0);
  assign err = 1'b0;
`endif

endmodule

// File: rtl/block_mix_ct.sv
// rtl/block_mix_ct.sv - scrypt BlockMix (r=1) datapath around the Salsa20/8 core handshake
// Optional Salsa wait timeout compiled in with BLOCK_MIX_TIMEOUT_EN.
module block_mix_ct
  import scrypt_pkg::*;
#(
  parameter int SALSA_TIMEOUT = SALSA_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic [BLOCK_W-1:0] block_in,
  output logic               valid,
  output logic [BLOCK_W-1:0] block_out,
  output logic               salsa_init,
  output logic [HALF_W-1:0]  salsa_in,
  input  logic               salsa_valid,
  input  logic [HALF_W-1:0]  salsa_out,
  output logic               err
);

  logic [HALF_W-1:0] b0_reg, b1_reg, y0_reg, y1_reg;
  logic load_b, mix0, mix1, cap_y0, cap_y1;

  block_mix_fsm #(.SALSA_TIMEOUT(SALSA_TIMEOUT)) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .salsa_valid (salsa_valid),
    .load_b      (load_b),
    .mix0        (mix0),
    .mix1        (mix1),
    .cap_y0      (cap_y0),
    .cap_y1      (cap_y1),
    .salsa_init  (salsa_init),
    .valid       (valid),
    .err         (err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b0_reg <= '0;
      b1_reg <= '0;
      y0_reg <= '0;
      y1_reg <= '0;
    end else begin
      if (load_b) begin
        b0_reg <= block_in[HALF_W-1:0];
        b1_reg <= block_in[BLOCK_W-1:HALF_W];
      end
      if (cap_y0) y0_reg <= salsa_out;
      if (cap_y1) y1_reg <= salsa_out;
    end
  end

  // Core input is held steady from registers for the whole MIX interval.
  assign salsa_in  = mix0 ? (b0_reg ^ b1_reg) :
                     mix1 ? (y0_reg ^ b1_reg) : '0;
  assign block_out = {y1_reg, y0_reg};

endmodule

// File: tb/tb_block_mix_ct.sv
// tb/tb_block_mix_ct.sv - randomized bench for block_mix_ct against a software BlockMix(r=1) model
module tb_block_mix_ct;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init = 1'b0;
  logic [1023:0] block_in = '0;
  logic          valid, salsa_init, salsa_valid, err;
  logic [1023:0] block_out;
  logic [511:0]  salsa_in, salsa_out;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  block_mix_ct dut (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .block_in    (block_in),
    .valid       (valid),
    .block_out   (block_out),
    .salsa_init  (salsa_init),
    .salsa_in    (salsa_in),
    .salsa_valid (salsa_valid),
    .salsa_out   (salsa_out),
    .err         (err)
  );

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic void qr(inout logic [15:0][31:0] x, input int a, input int b, input int c, input int d);
    x[b] = x[b] ^ rotl(x[a] + x[d], 7);
    x[c] = x[c] ^ rotl(x[b] + x[a], 9);
    x[d] = x[d] ^ rotl(x[c] + x[b], 13);
    x[a] = x[a] ^ rotl(x[d] + x[c], 18);
  endfunction

  function automatic logic [511:0] salsa8(input logic [511:0] in);
    logic [15:0][31:0] x, w, o;
    x = in;
    w = in;
    for (int r = 0; r < 4; r++) begin
      qr(x, 0, 4, 8, 12);  qr(x, 5, 9, 13, 1);  qr(x, 10, 14, 2, 6);  qr(x, 15, 3, 7, 11);
      qr(x, 0, 1, 2, 3);   qr(x, 5, 6, 7, 4);   qr(x, 10, 11, 8, 9);  qr(x, 15, 12, 13, 14);
    end
    for (int i = 0; i < 16; i++) o[i] = x[i] + w[i];
    return o;
  endfunction

  function automatic logic [1023:0] blockmix_ref(input logic [1023:0] b);
    logic [511:0] x, y0, y1;
    x  = b[1023:512];
    y0 = salsa8(x ^ b[511:0]);
    y1 = salsa8(y0 ^ b[1023:512]);
    return {y1, y0};
  endfunction

  function automatic logic [1023:0] rand_block();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Behavioural Salsa20/8 core: samples init, 7 round states, then holds DONE until init drops.
  logic         core_busy, core_done, stuck = 1'b0;
  int           core_cnt;
  logic [511:0] core_res;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_busy <= 1'b0;
      core_done <= 1'b0;
      core_cnt  <= 0;
      core_res  <= '0;
    end else if (core_done) begin
      if (!salsa_init) core_done <= 1'b0;
    end else if (core_busy) begin
      if (core_cnt == 7 && !stuck) begin
        core_busy <= 1'b0;
        core_done <= 1'b1;
      end else if (core_cnt < 7) begin
        core_cnt <= core_cnt + 1;
      end
    end else if (salsa_init) begin
      core_busy <= 1'b1;
      core_cnt  <= 1;
      core_res  <= salsa8(salsa_in);
    end
  end

  assign salsa_valid = core_done;
  assign salsa_out   = core_done ? core_res : '0;

  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    int k;
    k = 0;
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      for (int i = 7; i >= 0; i--) if (got[128*i +: 128] !== exp[128*i +: 128]) k = i;
      $display("FAIL %s: got %h expected %h (128-bit chunk %0d)", tag, got[128*k +: 128], exp[128*k +: 128], k);
    end
  endtask

  task automatic do_mix(input logic [1023:0] b, input int drop_at, input string tag);
    logic [1023:0] exp;
    logic [511:0]  in0, in1, seen0, seen1;
    int            inv, gap, vedge, hold;
    logic          prev_si;
    exp   = blockmix_ref(b);
    in0   = b[511:0] ^ b[1023:512];
    in1   = exp[511:0] ^ b[1023:512];
    seen0 = '1;
    seen1 = '1;
    inv   = 0;
    gap   = 0;
    vedge = -1;
    prev_si = 1'b0;
    @(negedge clk);
    block_in = b;
    init = 1'b1;
    for (int c = 0; c < 60 && vedge < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      block_in = ~b;
      if (c == drop_at) init = 1'b0;
      if (salsa_init && !prev_si) begin
        inv++;
        if (inv == 1) seen0 = salsa_in;
        else if (inv == 2) seen1 = salsa_in;
      end
      if (!salsa_init && inv == 1) gap++;
      prev_si = salsa_init;
      if (valid) vedge = c + 1;
    end
    check({tag, "_salsa_in0"}, seen0, in0);
    check({tag, "_salsa_in1"}, seen1, in1);
    check({tag, "_gap"}, gap, 1);
    check({tag, "_invocations"}, inv, 2);
    check({tag, "_latency"}, vedge, 21);
    check({tag, "_block_out"}, block_out, exp);
    check({tag, "_err"}, err, 1'b0);
    if (drop_at >= 0) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_valid_pulse"}, valid, 1'b0);
      check({tag, "_idle_init"}, salsa_init, 1'b0);
    end else begin
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        @(posedge clk);
        @(negedge clk);
      end
      check({tag, "_valid_hold"}, valid, 1'b1);
      check({tag, "_out_hold"}, block_out, exp);
      init = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_valid_drop"}, valid, 1'b0);
    end
  endtask

  initial begin
    logic [1023:0] r;
    logic [511:0]  h;
    repeat (2) @(negedge clk);
    check("rst_valid", valid, 1'b0);
    check("rst_salsa_init", salsa_init, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_block_out", block_out, '0);
    check("rst_salsa_in", salsa_in, '0);
    reset = 1'b0;

    do_mix('0, -1, "zero");

    h = rand_block();
    do_mix({h, h}, -1, "equal_halves");

    for (int i = 0; i < 1000; i++) do_mix(rand_block(), -1, "rand");

    do_mix(rand_block(), 4, "early_drop");

    @(negedge clk);
    block_in = rand_block();
    init = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    check("pre_rst_salsa_init", salsa_init, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_salsa_init", salsa_init, 1'b0);
    check("mid_rst_valid", valid, 1'b0);
    check("mid_rst_block_out", block_out, '0);
    check("mid_rst_salsa_in", salsa_in, '0);
    init = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    do_mix(rand_block(), -1, "post_rst");

`ifdef BLOCK_MIX_TIMEOUT_EN
    begin
      int eobs;
      eobs = -1;
      stuck = 1'b1;
      @(negedge clk);
      block_in = rand_block();
      init = 1'b1;
      for (int c = 0; c < 40 && eobs < 0; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (err) eobs = c;
      end
      check("to_latency", eobs, 15);
      check("to_salsa_init", salsa_init, 1'b0);
      check("to_valid", valid, 1'b0);
      repeat (2) begin
        @(posedge clk);
        @(negedge clk);
      end
      check("to_err_sticky", err, 1'b1);
      init = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("to_err_clear", err, 1'b0);
      check("to_idle_init", salsa_init, 1'b0);
      reset = 1'b1;
      stuck = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      do_mix(rand_block(), -1, "post_to");
    end
`endif

    r = rand_block();
    do_mix(r, -1, "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
